// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for the 8-bit ALU.
// Drives LFSR-generated operands and an index-derived opcode to the ALU.
// It compares each result against a golden model, counts mismatches and
// captures the first failing vector. Each vector takes two cycles:
// a DRIVE settle cycle, then a CHECK compare cycle.
module alu_bist #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        fail_valid,
  output logic [7:0]  fail_a,
  output logic [7:0]  fail_b,
  output logic [1:0]  fail_op,
  output logic [7:0]  fail_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // An all-zero seed would lock the LFSR at zero, so it is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Reference ALU behaviour; every result wraps modulo 256.
  function automatic logic [7:0] golden(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   golden = a + b;
      2'b01:   golden = a - b;
      2'b10:   golden = a & b;
      2'b11:   golden = a | b;
      default: golden = 8'h00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] vec_idx_q, vec_idx_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_count_q, err_count_d;
  logic        fail_valid_q, fail_valid_d;
  logic [7:0]  fail_a_q, fail_a_d;
  logic [7:0]  fail_b_q, fail_b_d;
  logic [1:0]  fail_op_q, fail_op_d;
  logic [7:0]  fail_result_q, fail_result_d;
  logic        mismatch;

  // Next-state, vector generation and result checking.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    vec_idx_d     = vec_idx_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_count_d   = err_count_q;
    fail_valid_d  = fail_valid_q;
    fail_a_d      = fail_a_q;
    fail_b_d      = fail_b_q;
    fail_op_d     = fail_op_q;
    fail_result_d = fail_result_q;
    mismatch      = (alu_result != golden(alu_a_q, alu_b_q, alu_op_q));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Fresh run: wipe previous results and present vector 0.
          state_d       = ST_DRIVE;
          lfsr_d        = SEED_EFF;
          vec_idx_d     = 16'h0000;
          alu_a_d       = SEED_EFF[7:0];
          alu_b_d       = SEED_EFF[15:8];
          alu_op_d      = 2'b00;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          err_count_d   = 16'h0000;
          fail_valid_d  = 1'b0;
          fail_a_d      = 8'h00;
          fail_b_d      = 8'h00;
          fail_op_d     = 2'b00;
          fail_result_d = 8'h00;
        end else begin
          state_d = state_q;
        end
      end

      ST_DRIVE: begin
        // Give the combinational ALU a full cycle to settle.
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end else begin
            err_count_d = err_count_q;
          end
          if (!fail_valid_q) begin
            fail_valid_d  = 1'b1;
            fail_a_d      = alu_a_q;
            fail_b_d      = alu_b_q;
            fail_op_d     = alu_op_q;
            fail_result_d = alu_result;
          end else begin
            fail_valid_d  = fail_valid_q;
          end
        end else begin
          err_count_d = err_count_q;
        end

        if (vec_idx_q == LAST_IDX) begin
          // Last vector checked; ALU outputs keep holding it.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = ST_DRIVE;
          lfsr_d    = lfsr_step(lfsr_q);
          vec_idx_d = vec_idx_q + 16'd1;
          alu_a_d   = lfsr_d[7:0];
          alu_b_d   = lfsr_d[15:8];
          alu_op_d  = vec_idx_d[1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    pass_d = done_d && (err_count_d == 16'h0000);
  end

  // State and output registers; reset clears every result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= 16'h0000;
      vec_idx_q     <= 16'h0000;
      alu_a_q       <= 8'h00;
      alu_b_q       <= 8'h00;
      alu_op_q      <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_count_q   <= 16'h0000;
      fail_valid_q  <= 1'b0;
      fail_a_q      <= 8'h00;
      fail_b_q      <= 8'h00;
      fail_op_q     <= 2'b00;
      fail_result_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      vec_idx_q     <= vec_idx_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_count_q   <= err_count_d;
      fail_valid_q  <= fail_valid_d;
      fail_a_q      <= fail_a_d;
      fail_b_q      <= fail_b_d;
      fail_op_q     <= fail_op_d;
      fail_result_q <= fail_result_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_count_q;
  assign fail_valid  = fail_valid_q;
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;
  assign fail_op     = fail_op_q;
  assign fail_result = fail_result_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: scoreboard bench for alu_bist with NUM_VECTORS=4.
// The bench plays the ALU (correct, SUB-as-ADD, or stuck-at-0).
// Expected vectors and verdicts are pushed when a run is started.
// They are popped as the DUT presents each vector.
module tb_alu_bist;

  localparam int NV = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        busy, done, pass, fail_valid;
  logic [15:0] err_count;
  logic [7:0]  fail_a, fail_b, fail_result;
  logic [1:0]  fail_op;
  int          mode;

  int n_cmp;
  int n_mis;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] obs;
    logic       bad;
  } vec_t;

  vec_t sb[$];

  alu_bist #(.NUM_VECTORS(NV), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
    .fail_op(fail_op), .fail_result(fail_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_gold(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // The ALU under test as seen by the sequencer, with optional planted faults.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op, input int m);
    if (m == 2) return 8'd0;
    if (m == 1 && op == 2'b01) return a + b;
    return ref_gold(a, b, op);
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_op, mode);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int m);
    logic [15:0] l;
    vec_t v;
    l = 16'hACE1;
    for (int k = 0; k < NV; k++) begin
      if (k > 0) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      v.a   = l[7:0];
      v.b   = l[15:8];
      v.op  = 2'(k);
      v.obs = alu_model(v.a, v.b, v.op, m);
      v.bad = (v.obs != ref_gold(v.a, v.b, v.op));
      sb.push_back(v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, alu_a, 0);
    check_eq({tag, "_b"}, alu_b, 0);
    check_eq({tag, "_op"}, alu_op, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_err"}, err_count, 0);
    check_eq({tag, "_fv"}, fail_valid, 0);
    check_eq({tag, "_fa"}, fail_a, 0);
    check_eq({tag, "_fb"}, fail_b, 0);
    check_eq({tag, "_fop"}, fail_op, 0);
    check_eq({tag, "_fres"}, fail_result, 0);
  endtask

  // One full run; edges counted from the start-accept edge (edge 0).
  task automatic do_run(input int m, input bit pulse_mid);
    vec_t        cur;
    int          exp_err;
    logic        exp_fv;
    logic [7:0]  efa, efb, efr;
    logic [1:0]  efo;
    int          k;
    mode    = m;
    exp_err = 0;
    exp_fv  = 1'b0;
    efa = 8'd0; efb = 8'd0; efr = 8'd0; efo = 2'd0;
    k = 0;
    cur = '{a: 8'd0, b: 8'd0, op: 2'd0, obs: 8'd0, bad: 1'b0};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    push_run(m);
    for (int e = 0; e <= 2 * NV; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (pulse_mid && e == 2) start = 1'b1;
      if (pulse_mid && e == 3) start = 1'b0;
      if (e >= 2 && (e % 2) == 0 && cur.bad) begin
        if (exp_err < 65535) exp_err++;
        if (!exp_fv) begin
          exp_fv = 1'b1;
          efa = cur.a; efb = cur.b; efo = cur.op; efr = cur.obs;
        end
      end
      check_eq("busy", busy, (e < 2 * NV) ? 1 : 0);
      check_eq("done", done, (e == 2 * NV) ? 1 : 0);
      check_eq("pass", pass, (e == 2 * NV && exp_err == 0) ? 1 : 0);
      check_eq("err_count", err_count, 32'(exp_err));
      check_eq("fail_valid", fail_valid, exp_fv);
      check_eq("fail_a", fail_a, efa);
      check_eq("fail_b", fail_b, efb);
      check_eq("fail_op", fail_op, efo);
      check_eq("fail_result", fail_result, efr);
      if ((e % 2) == 0 && e < 2 * NV) begin
        check_eq("sb_size", sb.size(), 32'(NV - k));
        if (sb.size() > 0) cur = sb.pop_front();
        k++;
      end
      if ((e % 2) == 0) begin
        check_eq("vec_a", alu_a, cur.a);
        check_eq("vec_b", alu_b, cur.b);
        check_eq("vec_op", alu_op, cur.op);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    mode  = 0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Correct ALU, with a start pulse mid-run that must be ignored.
    do_run(0, 1'b1);
    check_eq("m0_err", err_count, 0);
    check_eq("m0_pass", pass, 1);

    // SUB implemented as ADD, restarted from DONE.
    do_run(1, 1'b0);
    check_eq("m1_err", err_count, 1);
    check_eq("m1_fa", fail_a, 195);
    check_eq("m1_fb", fail_b, 89);
    check_eq("m1_fop", fail_op, 1);
    check_eq("m1_fres", fail_result, 28);

    // Result stuck at zero: only the first mismatch is captured.
    do_run(2, 1'b0);
    check_eq("m2_err", err_count, 4);
    check_eq("m2_fa", fail_a, 225);
    check_eq("m2_fb", fail_b, 172);
    check_eq("m2_fop", fail_op, 0);
    check_eq("m2_fres", fail_result, 0);

    // Restart from DONE reproduces the same run.
    do_run(2, 1'b0);
    check_eq("m2r_err", err_count, 4);

    // Reset mid-run at edge 5 of a faulty run.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    check_eq("pre_rst_err", err_count, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_run(2, 1'b0);
    check_eq("post_rst_err", err_count, 4);
    check_eq("post_rst_fa", fail_a, 225);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Self-test sequencer for the 8-bit `alu` (op encoding 00=ADD, 01=SUB, 10=AND, 11=OR). On `start` it drives pseudo-random operand/opcode vectors into the ALU and samples `alu_result`. It compares each result against an internal golden model, counts mismatches and captures the first failing vector. It replaces file-driven stimulus in hardware bring-up and in self-checking regressions.

## Interface
- `NUM_VECTORS`, 256: vectors per run; legal range 1..65535.
- `SEED`, 16'hACE1: LFSR seed; a value of 0 is replaced by 16'hACE1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: run request; sampled only in IDLE and DONE.
- `alu_a` output 8: operand A to the ALU (registered).
- `alu_b` output 8: operand B to the ALU (registered).
- `alu_op` output 2: opcode to the ALU (registered).
- `alu_result` input 8: combinational ALU result.
- `busy` output 1: run in progress.
- `done` output 1: run complete; held until the next accepted `start` or reset.
- `pass` output 1: `done` && `err_count`==0.
- `err_count` output 16: mismatch count; saturates at 16'hFFFF.
- `fail_valid` output 1: a mismatch has been captured this run.
- `fail_a`, `fail_b` output 8 each: operands of the first mismatch.
- `fail_op` output 2: opcode of the first mismatch.
- `fail_result` output 8: observed result of the first mismatch.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE or DONE with `start`=1:
  - clear `err_count`, `fail_*`, `done`, `vec_idx`.
  - load vector 0 from the seed.
  - set `busy`=1 and go to DRIVE.
- DRIVE: settle cycle only; go to CHECK.
- CHECK, at the clock edge ending the cycle:
  - compare `alu_result` with the expected value.
  - on mismatch: increment `err_count` (saturating); if `fail_valid`=0, capture `fail_*` and set `fail_valid`.
  - if `vec_idx`==NUM_VECTORS-1: go to DONE, `busy`=0, `done`=1.
  - otherwise: load the next vector, increment `vec_idx`, go to DRIVE.
- Stimulus generation:
  - 16-bit Fibonacci LFSR `lfsr`.
  - next value = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - vector k uses the LFSR value after k steps: `alu_a`=lfsr[7:0], `alu_b`=lfsr[15:8], `alu_op`=vec_idx[1:0].
  - the LFSR steps once per vector load after vector 0.
- Golden model, all results mod 256:
  - ADD: a+b.
  - SUB: a-b (two's-complement wrap).
  - AND: a&b.
  - OR: a|b.
- `start` in DRIVE or CHECK is ignored.
- In DONE, the ALU outputs hold the last vector.

## Timing
- Reset values:
  - state IDLE.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `busy`, `done`, `pass`, `fail_valid` = 0.
  - `err_count` and all `fail_*` = 0.
- Vector cadence:
  - 2 cycles per vector.
  - vector k appears on the ALU outputs at edge 2k after the start-accept edge (edge 0).
  - vector k is compared at edge 2k+2.
- Run length:
  - `done` rises at edge 2·NUM_VECTORS after the start-accept edge.
  - `busy` is high from edge 0 through edge 2·NUM_VECTORS-1.
- `err_count` and `fail_*` update at the same edge as the compare.
- Reset asserted mid-run returns every output to its reset value immediately; no partial results are retained.
- Restarting from DONE reproduces an identical vector sequence.

## Test plan
- Correct ALU, NUM_VECTORS=4, default SEED → vectors:
  - (a=225, b=172, ADD, expect 141)
  - (195, 89, SUB, 106)
  - (135, 179, AND, 131)
  - (15, 103, OR, 111)
  - `done` at edge 8, `err_count`=0, `pass`=1.
- ALU with SUB implemented as ADD, NUM_VECTORS=4 → `err_count`=1, `fail_a`=195, `fail_b`=89, `fail_op`=01, `fail_result`=28, `pass`=0.
- `alu_result` stuck at 0, NUM_VECTORS=4 → `err_count`=4; `fail_*` = (225, 172, 00, 0), i.e. only the first mismatch is captured.
- Pulse `start` at edge 3 of a run → no effect; `done` still at edge 8.
- Assert `rst_n`=0 at edge 5 of a faulty run → all outputs 0 immediately. A subsequent `start` then produces results identical to a fresh run.
- After `done`, assert `start` → counters and `fail_*` clear and `done` drops at that edge. The same vector sequence and the same `err_count` are reproduced.
